// File: rtl/vx_alu_route_unit.sv
// N-way ALU sub-unit router/merger: select-based request fan-out, per-lane pending throttle, arbitrated response merge.
// Optional perf counters are enabled by defining ALU_ROUTE_PERF_EN.
module vx_alu_route_unit #(
  parameter int unsigned NUM_SUBUNITS = 2,
  parameter int unsigned DATAW_IN     = 64,
  parameter int unsigned DATAW_OUT    = 64,
  parameter int unsigned SEL_BITS     = (NUM_SUBUNITS > 1) ? $clog2(NUM_SUBUNITS) : 1,
  parameter int unsigned ARB_MODE     = 1,
  parameter int unsigned OUT_REG      = 1,
  parameter int unsigned MAX_PENDING  = 8,
  parameter int unsigned PERF_W       = 32
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              req_valid,
  output logic                              req_ready,
  input  logic [DATAW_IN-1:0]               req_data,
  input  logic [SEL_BITS-1:0]               req_sel,
  input  logic                              drain,
  output logic [NUM_SUBUNITS-1:0]           sub_req_valid,
  input  logic [NUM_SUBUNITS-1:0]           sub_req_ready,
  output logic [NUM_SUBUNITS*DATAW_IN-1:0]  sub_req_data,
  input  logic [NUM_SUBUNITS-1:0]           sub_rsp_valid,
  output logic [NUM_SUBUNITS-1:0]           sub_rsp_ready,
  input  logic [NUM_SUBUNITS*DATAW_OUT-1:0] sub_rsp_data,
  output logic                              rsp_valid,
  input  logic                              rsp_ready,
  output logic [DATAW_OUT-1:0]              rsp_data,
  output logic [SEL_BITS-1:0]               rsp_sel,
  output logic                              idle,
  output logic                              sel_err
`ifdef ALU_ROUTE_PERF_EN
  ,
  output logic [NUM_SUBUNITS*PERF_W-1:0]    perf_issue_cnt,
  output logic [PERF_W-1:0]                 perf_stall_cnt
`endif
);

  localparam int unsigned N     = NUM_SUBUNITS;
  localparam int unsigned PW    = $clog2(MAX_PENDING + 1);
  localparam int unsigned SW1   = SEL_BITS + 1;
  localparam logic [PW-1:0] MAX_P = PW'(MAX_PENDING);

  typedef struct packed {
    logic [SEL_BITS-1:0]  sel;
    logic [DATAW_OUT-1:0] data;
  } rsp_ent_t;

  logic [PW-1:0]       pending_q [N];
  logic [N-1:0]        ok;
  logic [N-1:0]        sub_fire_req;
  logic [N-1:0]        sub_fire_rsp;
  logic                sel_ok;
  logic                sel_hit_ready;
  logic                req_fire;
  logic                sel_err_q;
  logic [SEL_BITS-1:0] last_q;
  logic [31:0]         arb_start;
  logic [N-1:0]        grant;
  logic [SEL_BITS-1:0] grant_idx;
  logic [DATAW_OUT-1:0] grant_data;
  logic                any_valid;
  logic                out_can_accept;
  logic                rsp_in_fire;
  logic                out_empty;
  logic                pend_zero;

  // Out-of-range selects only exist when N is not a power of two.
  generate
    if ((1 << SEL_BITS) > N) begin : g_sel_chk
      assign sel_ok = {1'b0, req_sel} < SW1'(N);
    end else begin : g_sel_full
      assign sel_ok = 1'b1;
    end
  endgenerate

  always_comb begin
    ok            = '0;
    sub_req_valid = '0;
    sel_hit_ready = 1'b0;
    for (int i = 0; i < N; i++) begin
      ok[i]            = pending_q[i] < MAX_P;
      sub_req_valid[i] = req_valid & ~drain & (req_sel == SEL_BITS'(i)) & ok[i];
      if (req_sel == SEL_BITS'(i)) sel_hit_ready = sub_req_ready[i] & ok[i];
    end
  end

  assign req_ready    = ~drain & (sel_ok ? sel_hit_ready : 1'b1);
  assign req_fire     = req_valid & req_ready;
  assign sub_req_data = {N{req_data}};
  assign sub_fire_req = sub_req_valid & sub_req_ready;
  assign sub_fire_rsp = sub_rsp_valid & sub_rsp_ready;

  // Outstanding-op tracking; simultaneous issue and return cancel out.
  always_ff @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (reset) begin
        pending_q[i] <= '0;
      end else begin
        assert (!(sub_fire_rsp[i] && !sub_fire_req[i] && pending_q[i] == '0));
        if (sub_fire_req[i] && !sub_fire_rsp[i]) pending_q[i] <= pending_q[i] + PW'(1);
        else if (!sub_fire_req[i] && sub_fire_rsp[i]) pending_q[i] <= pending_q[i] - PW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) sel_err_q <= 1'b0;
    else if (req_fire && !sel_ok) sel_err_q <= 1'b1;
  end
  assign sel_err = sel_err_q;

  function automatic int unsigned rot_idx(input logic [31:0] start, input int unsigned k);
    return (start + k) % N;
  endfunction

  assign arb_start = (ARB_MODE == 1) ? (32'(last_q) + 32'd1) : 32'd0;

  // Walk the search order backwards so the first valid candidate wins.
  always_comb begin
    grant      = '0;
    grant_idx  = '0;
    grant_data = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (sub_rsp_valid[rot_idx(arb_start, k)]) begin
        grant                          = '0;
        grant[rot_idx(arb_start, k)]   = 1'b1;
        grant_idx                      = SEL_BITS'(rot_idx(arb_start, k));
      end
    end
    for (int i = 0; i < N; i++) begin
      if (grant[i]) grant_data = sub_rsp_data[i*DATAW_OUT +: DATAW_OUT];
    end
  end

  assign any_valid     = |sub_rsp_valid;
  assign rsp_in_fire   = any_valid & out_can_accept;
  assign sub_rsp_ready = grant & {N{out_can_accept}};

  always_ff @(posedge clk) begin
    if (reset) last_q <= SEL_BITS'(N - 1);
    else if (rsp_in_fire) last_q <= grant_idx;
  end

  generate
    if (OUT_REG == 0) begin : g_comb_out
      assign rsp_valid      = any_valid;
      assign rsp_data       = grant_data;
      assign rsp_sel        = grant_idx;
      assign out_can_accept = rsp_ready;
      assign out_empty      = 1'b1;
    end else begin : g_skid_out
      // Two entries let a full-rate stream continue without ready feeding back combinationally.
      rsp_ent_t   ent_q [2];
      logic       wr_ptr_q;
      logic       rd_ptr_q;
      logic [1:0] cnt_q;
      logic       pop;

      assign pop = (cnt_q != 2'd0) & rsp_ready;

      always_ff @(posedge clk) begin
        if (reset) begin
          wr_ptr_q <= 1'b0;
          rd_ptr_q <= 1'b0;
          cnt_q    <= 2'd0;
        end else begin
          if (rsp_in_fire) wr_ptr_q <= ~wr_ptr_q;
          if (pop)         rd_ptr_q <= ~rd_ptr_q;
          cnt_q <= cnt_q + 2'(rsp_in_fire) - 2'(pop);
        end
      end

      always_ff @(posedge clk) begin
        if (rsp_in_fire) ent_q[wr_ptr_q] <= '{sel: grant_idx, data: grant_data};
      end

      assign rsp_valid      = cnt_q != 2'd0;
      assign rsp_data       = ent_q[rd_ptr_q].data;
      assign rsp_sel        = ent_q[rd_ptr_q].sel;
      assign out_can_accept = ~cnt_q[1];
      assign out_empty      = cnt_q == 2'd0;
    end
  endgenerate

  always_comb begin
    pend_zero = 1'b1;
    for (int i = 0; i < N; i++) begin
      if (pending_q[i] != '0) pend_zero = 1'b0;
    end
  end
  assign idle = pend_zero & out_empty;

`ifdef ALU_ROUTE_PERF_EN
  logic [PERF_W-1:0] issue_cnt_q [N];
  logic [PERF_W-1:0] stall_cnt_q;

  always_ff @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (reset) issue_cnt_q[i] <= '0;
      else if (sub_fire_req[i]) issue_cnt_q[i] <= issue_cnt_q[i] + PERF_W'(1);
    end
    if (reset) stall_cnt_q <= '0;
    else if (req_valid && !req_ready && !drain) stall_cnt_q <= stall_cnt_q + PERF_W'(1);
  end

  for (genvar g = 0; g < N; g++) begin : g_perf
    assign perf_issue_cnt[g*PERF_W +: PERF_W] = issue_cnt_q[g];
  end
  assign perf_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: doc/vx_alu_route_unit.md
# vx_alu_route_unit

Generalised ALU sub-unit router/merger. Routes each dispatched ALU request to one of `NUM_SUBUNITS` execution sub-units (int, muldiv, and later bitmanip or crypto) by a pre-decoded select, tracks outstanding ops per sub-unit, and merges the sub-unit responses onto one commit stream through a configurable arbiter and output stage. It sits between an ALU block's execute stream and its commit stream, replacing the fixed two-way int/muldiv split with an N-way, drainable, throttled router.

## Interface
- `NUM_SUBUNITS`, 2: number of sub-units (≥1)
- `DATAW_IN`, 64: request payload width
- `DATAW_OUT`, 64: response payload width
- `SEL_BITS`, `UP(CLOG2(NUM_SUBUNITS))`: derived; do not override
- `ARB_MODE`, 1: 0 = fixed priority (lowest index wins), 1 = round-robin
- `OUT_REG`, 1: 0 = combinational output, 1 = 2-entry skid buffer
- `MAX_PENDING`, 8: per-sub-unit outstanding-op cap (≥1)
- `PERF_W`, 32: perf counter width

Ports (one clock; reset is synchronous and active-high):
- `clk` in 1: clock
- `reset` in 1: synchronous active-high reset
- `req_valid` / `req_ready` in 1 / out 1: request handshake
- `req_data` in DATAW_IN: request payload
- `req_sel` in SEL_BITS: target sub-unit index
- `drain` in 1: block new requests
- `sub_req_valid` out NUM_SUBUNITS; `sub_req_ready` in NUM_SUBUNITS
- `sub_req_data` out NUM_SUBUNITS*DATAW_IN: `req_data` replicated per lane
- `sub_rsp_valid` in NUM_SUBUNITS; `sub_rsp_ready` out NUM_SUBUNITS
- `sub_rsp_data` in NUM_SUBUNITS*DATAW_OUT: lane i at bits [i*DATAW_OUT +: DATAW_OUT]
- `rsp_valid` out 1; `rsp_ready` in 1; `rsp_data` out DATAW_OUT; `rsp_sel` out SEL_BITS: source sub-unit
- `idle` out 1: no outstanding ops and output stage empty
- `sel_err` out 1: sticky, out-of-range `req_sel` seen
- `perf_issue_cnt` out NUM_SUBUNITS*PERF_W; `perf_stall_cnt` out PERF_W (only with `ALU_ROUTE_PERF_EN`)

## Operation
- Request path is combinational. `ok[i] = pending[i] < MAX_PENDING`. `sub_req_valid[i] = req_valid & ~drain & (req_sel==i) & ok[i]`. `req_ready = ~drain & sub_req_ready[req_sel] & ok[req_sel]`.
- `req_sel ≥ NUM_SUBUNITS` (non-power-of-2 counts only): request is consumed (`req_ready=1` unless `drain`), no sub-unit is driven, `sel_err` is set. Only reset clears it.
- `pending[i]`, width `CLOG2(MAX_PENDING+1)`: +1 on sub-request fire, −1 on `sub_rsp_valid[i] & sub_rsp_ready[i]`, unchanged when both occur in the same cycle. A decrement at 0 is an assertion failure.
- Arbiter candidates: all `sub_rsp_valid` bits. Mode 0 grants the lowest index. Mode 1 searches from `last+1` with wrap. `last` updates only on a response fire.
- `sub_rsp_ready[g] = grant[g] & out_can_accept`. Every non-granted lane has ready 0.
- OUT_REG=0: `rsp_valid = |sub_rsp_valid`, `out_can_accept = rsp_ready`.
- OUT_REG=1: 2-entry skid buffer carrying {sel, data}. `out_can_accept = ~skid_full`, registered with no combinational path from `rsp_ready`. Full throughput when `rsp_ready=1`. Order is preserved.
- `idle = (all pending==0) & output stage empty`. Drain completes when `drain=1` and `idle=1`.

## Timing
- Reset values: `rsp_valid=0`, `sel_err=0`, `idle=1`, all `pending=0`, skid buffer empty, `last=NUM_SUBUNITS-1` (sub-unit 0 wins first), perf counters 0. `rsp_data`/`rsp_sel` are don't-care while `rsp_valid=0`.
- Request latency: 0 cycles.
- Response latency: OUT_REG cycles (0 or 1) from sub-unit fire to `rsp_valid`.
- `rsp_valid`/`rsp_data` stay stable while stalled.
- Reset mid-operation: all state clears in the same cycle. In-flight sub-unit ops are the sub-units' own reset responsibility.
- `drain` acts in the same cycle. A request presented with `drain` is not accepted. Responses keep flowing.
- NUM_SUBUNITS=1: arbiter degenerates to pass-through; `rsp_sel=0`.

## Configuration
- `ALU_ROUTE_PERF_EN` defined:
  - `perf_issue_cnt[i]` increments on each sub-request fire to lane i.
  - `perf_stall_cnt` increments each cycle with `req_valid & ~req_ready & ~drain`.
  - Both wrap at 2^PERF_W.
- Not defined: perf ports are absent and no counters are synthesised. All other behaviour is identical.

## Test plan
- Round-robin fairness: ARB_MODE=1, NUM_SUBUNITS=3, all `sub_rsp_valid` held 1, `rsp_ready=1` → `rsp_sel` sequence 0,1,2,0,1,2; one response per cycle after 1-cycle latency.
- Fixed priority: ARB_MODE=0, lanes 0 and 2 valid → lane 0 drains fully before lane 2. Lane 2 `sub_rsp_ready` stays 0 until then.
- Throttle: MAX_PENDING=2, no responses, three requests to lane 1 → first two accepted, third sees `req_ready=0`. One lane-1 response → third accepted next cycle.
- Backpressure: OUT_REG=1, `rsp_ready=0` for 5 cycles with lane 0 streaming → skid holds 2 entries, `sub_rsp_ready[0]=0`, no data lost. Order preserved after release.
- Drain/idle: 3 ops outstanding, assert `drain` → `req_ready=0`; `idle` rises the cycle after the last response leaves the output stage.
- Bad select: NUM_SUBUNITS=3, `req_sel=3` → `req_ready=1`, no `sub_req_valid`, `sel_err=1` and held until reset.
